// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the registered ALU sequencer.
//   - 5-bit opcode constants
//   - FSM state type {IDLE, SHIFT}
//   - shifter direction type and a helper that flags the shift opcodes
package ula_pkg;

    localparam logic [4:0] OP_ADD       = 5'b00000;
    localparam logic [4:0] OP_ADDINC    = 5'b00001;
    localparam logic [4:0] OP_BEQ       = 5'b00010;
    localparam logic [4:0] OP_INCA      = 5'b00011;
    localparam logic [4:0] OP_SUBDEC    = 5'b00100;
    localparam logic [4:0] OP_SUB       = 5'b00101;
    localparam logic [4:0] OP_DECA      = 5'b00110;
    localparam logic [4:0] OP_BNE       = 5'b00111;
    localparam logic [4:0] OP_LSL       = 5'b01000;
    localparam logic [4:0] OP_ASR       = 5'b01001;
    localparam logic [4:0] OP_JUMP      = 5'b01010;
    localparam logic [4:0] OP_MRG_BA    = 5'b01011;
    localparam logic [4:0] OP_MRG_AB    = 5'b01100;
    localparam logic [4:0] OP_LSR       = 5'b01101;
    localparam logic [4:0] OP_ZEROS     = 5'b10000;
    localparam logic [4:0] OP_AND       = 5'b10001;
    localparam logic [4:0] OP_NOTA_AND_B = 5'b10010;
    localparam logic [4:0] OP_PASSB     = 5'b10011;
    localparam logic [4:0] OP_A_AND_NOTB = 5'b10100;
    localparam logic [4:0] OP_PASSA     = 5'b10101;
    localparam logic [4:0] OP_XOR       = 5'b10110;
    localparam logic [4:0] OP_OR        = 5'b10111;
    localparam logic [4:0] OP_NOR       = 5'b11000;
    localparam logic [4:0] OP_XNOR      = 5'b11001;
    localparam logic [4:0] OP_NOTA      = 5'b11010;
    localparam logic [4:0] OP_NOTA_OR_B = 5'b11011;
    localparam logic [4:0] OP_NOTB      = 5'b11100;
    localparam logic [4:0] OP_A_OR_NOTB = 5'b11101;
    localparam logic [4:0] OP_NAND      = 5'b11110;
    localparam logic [4:0] OP_ONES      = 5'b11111;

    typedef enum logic {IDLE, SHIFT} state_t;

    typedef enum logic [1:0] {SH_LSL, SH_ASR, SH_LSR} shift_kind_t;

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == OP_LSL) || (op == OP_ASR) || (op == OP_LSR);
    endfunction

endpackage

// File: rtl/ula_shifter.sv
// ula_shifter: iterative one-bit-per-cycle shifter.
//   clock, reset   : clock, synchronous active-high reset
//   start          : load data_in / amount / kind (amount must be > 0)
//   kind           : shift direction/type
//   data_in        : value to shift
//   amount         : number of bit positions
//   advance        : permission to take the final step (output slot free)
//   done           : final step taken this cycle; data_out/carry_out are the result
//   data_out       : data after the step taken this cycle
//   carry_out      : bit shifted out by the step taken this cycle
module ula_shifter
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  shift_kind_t      kind,
    input  logic [WIDTH-1:0] data_in,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  logic             advance,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] data;
    shift_kind_t      kind_q;
    logic             step;

    always_comb begin
        data_out  = data;
        carry_out = 1'b0;
        case (kind_q)
            SH_LSL: begin
                data_out  = {data[WIDTH-2:0], 1'b0};
                carry_out = data[WIDTH-1];
            end
            SH_ASR: begin
                data_out  = {data[WIDTH-1], data[WIDTH-1:1]};
                carry_out = data[0];
            end
            default: begin
                data_out  = {1'b0, data[WIDTH-1:1]};
                carry_out = data[0];
            end
        endcase
    end

    // The last step is withheld until the output register can take it,
    // so the counter parks at 1 during a stall.
    assign done = (count == SHW'(1)) && advance;
    assign step = (count > SHW'(1)) || done;

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            data   <= '0;
            kind_q <= SH_LSL;
        end else if (start) begin
            count  <= amount;
            data   <= data_in;
            kind_q <= kind;
        end else if (step) begin
            count  <= count - SHW'(1);
            data   <= data_out;
        end
    end

endmodule

// File: rtl/ula_seq.sv
// ula_seq: registered ALU with valid/ready handshakes on both sides.
//   clock, reset              : clock, synchronous active-high reset
//   in_valid / in_ready       : request handshake (in_ready combinational)
//   opcode, a, b              : operation and operands; b[SHW-1:0] = shift amount
//   out_valid / out_ready     : result handshake
//   result, zero, carry, overflow, negative, cond : registered result and flags
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting requests; single-cycle ops load the output register
// SHIFT | iterative shift in progress; requests blocked
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             cond
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic             accept, shift_start, load_direct;
    logic             is_shift, shift_nz;
    logic [SHW-1:0]   shift_amt;
    shift_kind_t      sh_kind;
    logic             sh_done, sh_carry, sh_advance;
    logic [WIDTH-1:0] sh_data;

    logic [WIDTH-1:0] b_op;
    logic             cin, arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] comb_result;
    logic             comb_carry, comb_ovf, comb_cond;

    assign shift_amt = b[SHW-1:0];
    assign is_shift  = is_shift_op(opcode);
    assign shift_nz  = (shift_amt != '0);
    assign sh_kind   = (opcode == OP_LSL) ? SH_LSL :
                       (opcode == OP_ASR) ? SH_ASR : SH_LSR;

    // Shared adder: subtracts use A + ~B + cin so carry reads as no-borrow.
    always_comb begin
        b_op  = b;
        cin   = 1'b0;
        arith = 1'b0;
        case (opcode)
            OP_ADD:                  arith = 1'b1;
            OP_ADDINC:       begin arith = 1'b1; cin = 1'b1; end
            OP_INCA:         begin arith = 1'b1; b_op = '0; cin = 1'b1; end
            OP_SUBDEC:       begin arith = 1'b1; b_op = ~b; end
            OP_SUB, OP_BEQ, OP_BNE:
                             begin arith = 1'b1; b_op = ~b; cin = 1'b1; end
            OP_DECA:         begin arith = 1'b1; b_op = '1; end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, b_op} + (WIDTH+1)'(cin);
    end

    always_comb begin
        comb_result = '0;
        comb_carry  = 1'b0;
        comb_ovf    = 1'b0;
        comb_cond   = 1'b0;
        if (arith) begin
            comb_result = sum[WIDTH-1:0];
            comb_carry  = sum[WIDTH];
            comb_ovf    = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        case (opcode)
            OP_BEQ:        comb_cond = (a == b);
            OP_BNE:        comb_cond = (a != b);
            OP_JUMP:       begin comb_result = a; comb_cond = 1'b1; end
            // Only the zero-amount shift takes this path.
            OP_LSL, OP_ASR, OP_LSR: comb_result = a;
            OP_MRG_BA:     comb_result = {b[WIDTH-1:WIDTH/2], a[WIDTH/2-1:0]};
            OP_MRG_AB:     comb_result = {a[WIDTH-1:WIDTH/2], b[WIDTH/2-1:0]};
            OP_ZEROS:      comb_result = '0;
            OP_AND:        comb_result = a & b;
            OP_NOTA_AND_B: comb_result = ~a & b;
            OP_PASSB:      comb_result = b;
            OP_A_AND_NOTB: comb_result = a & ~b;
            OP_PASSA:      comb_result = a;
            OP_XOR:        comb_result = a ^ b;
            OP_OR:         comb_result = a | b;
            OP_NOR:        comb_result = ~a & ~b;
            OP_XNOR:       comb_result = ~(a ^ b);
            OP_NOTA:       comb_result = ~a;
            OP_NOTA_OR_B:  comb_result = ~a | b;
            OP_NOTB:       comb_result = ~b;
            OP_A_OR_NOTB:  comb_result = a | ~b;
            OP_NAND:       comb_result = ~(a & b);
            OP_ONES:       comb_result = '1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (shift_start) state_nxt = SHIFT;
            SHIFT:   if (sh_done)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE) && (!out_valid || out_ready);
        accept      = in_valid && in_ready;
        shift_start = accept && is_shift && shift_nz;
        load_direct = accept && !(is_shift && shift_nz);
        sh_advance  = !out_valid || out_ready;
    end

    ula_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .start     (shift_start),
        .kind      (sh_kind),
        .data_in   (a),
        .amount    (shift_amt),
        .advance   (sh_advance),
        .done      (sh_done),
        .data_out  (sh_data),
        .carry_out (sh_carry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            cond      <= 1'b0;
        end else if (load_direct) begin
            out_valid <= 1'b1;
            result    <= comb_result;
            zero      <= (comb_result == '0);
            carry     <= comb_carry;
            overflow  <= comb_ovf;
            negative  <= comb_result[WIDTH-1];
            cond      <= comb_cond;
        end else if (sh_done) begin
            out_valid <= 1'b1;
            result    <= sh_data;
            zero      <= (sh_data == '0);
            carry     <= sh_carry;
            overflow  <= 1'b0;
            negative  <= sh_data[WIDTH-1];
            cond      <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed vector table, hand-written multi-cycle sequences and a
// randomized run checked against an arithmetic reference model.
module tb_ula_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  opcode = 5'b0;
    logic [31:0] a = 32'b0;
    logic [31:0] b = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, carry, overflow, negative, cond;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    ula_seq #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .cond      (cond)
    );

    // flags packed as {zero, carry, overflow, negative, cond}
    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  f;
    } res_t;

    typedef struct {
        string       nm;
        logic [4:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] r;
        logic [4:0]  f;
    } vec_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {27'b0, zero, carry, overflow, negative, cond};
    endfunction

    function automatic vec_t mk(input string nm, input logic [4:0] op, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] r, input logic [4:0] f);
        vec_t v;
        v.nm = nm; v.op = op; v.va = va; v.vb = vb; v.r = r; v.f = f;
        return v;
    endfunction

    // Reference model: plain 64-bit arithmetic on the operand values.
    function automatic res_t ref_op(input logic [4:0] op, input logic [31:0] a_i, input logic [31:0] b_i);
        longint ua, ub, sa, sb, us, ss;
        logic [31:0] r;
        logic c, v, cd, ar;
        int n;
        res_t o;
        ua = longint'({32'b0, a_i});
        ub = longint'({32'b0, b_i});
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        us = 0; ss = 0; r = '0; c = 1'b0; v = 1'b0; cd = 1'b0; ar = 1'b0;
        n = int'(b_i[4:0]);
        case (op)
            5'b00000: begin us = ua + ub;     ss = sa + sb;     c = (us > 64'hFFFFFFFF); ar = 1'b1; end
            5'b00001: begin us = ua + ub + 1; ss = sa + sb + 1; c = (us > 64'hFFFFFFFF); ar = 1'b1; end
            5'b00011: begin us = ua + 1;      ss = sa + 1;      c = (us > 64'hFFFFFFFF); ar = 1'b1; end
            5'b00100: begin us = ua - ub - 1; ss = sa - sb - 1; c = (ua > ub);  ar = 1'b1; end
            5'b00010, 5'b00101, 5'b00111:
                      begin us = ua - ub;     ss = sa - sb;     c = (ua >= ub); ar = 1'b1; end
            5'b00110: begin us = ua - 1;      ss = sa - 1;      c = (ua != 0);  ar = 1'b1; end
            5'b01000: begin r = a_i << n;  c = (n != 0) ? a_i[32-n] : 1'b0; end
            5'b01001: begin r = $signed(a_i) >>> n; c = (n != 0) ? a_i[n-1] : 1'b0; end
            5'b01101: begin r = a_i >> n;  c = (n != 0) ? a_i[n-1] : 1'b0; end
            5'b01010: begin r = a_i; cd = 1'b1; end
            5'b01011: r = {b_i[31:16], a_i[15:0]};
            5'b01100: r = {a_i[31:16], b_i[15:0]};
            5'b10000: r = 32'h0;
            5'b10001: r = a_i & b_i;
            5'b10010: r = ~a_i & b_i;
            5'b10011: r = b_i;
            5'b10100: r = a_i & ~b_i;
            5'b10101: r = a_i;
            5'b10110: r = a_i ^ b_i;
            5'b10111: r = a_i | b_i;
            5'b11000: r = ~a_i & ~b_i;
            5'b11001: r = ~(a_i ^ b_i);
            5'b11010: r = ~a_i;
            5'b11011: r = ~a_i | b_i;
            5'b11100: r = ~b_i;
            5'b11101: r = a_i | ~b_i;
            5'b11110: r = ~(a_i & b_i);
            5'b11111: r = 32'hFFFFFFFF;
            default:  r = 32'h0;
        endcase
        if (ar) begin
            r = us[31:0];
            v = (ss > SMAX) || (ss < SMIN);
        end
        if (op == 5'b00010) cd = (a_i == b_i);
        if (op == 5'b00111) cd = (a_i != b_i);
        o.r = r;
        o.f = {(r == 32'h0), c, v, r[31], cd};
        return o;
    endfunction

    function automatic int latency(input logic [4:0] op, input logic [31:0] b_i);
        if ((op == 5'b01000 || op == 5'b01001 || op == 5'b01101) && b_i[4:0] != 5'd0)
            return 1 + int'(b_i[4:0]);
        return 1;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[$];
    int   cyc, busy_until, m_at;
    bit   m_has, mvalid, exp_inr, saw;
    res_t m_res;

    initial begin
        // reset with a request presented; it must be ignored
        reset = 1'b1; in_valid = 1'b1; opcode = 5'b00000; a = 32'd7; b = 32'd9;
        repeat (3) tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_result", result, 0);
        chk("reset_flags", flags(), 0);
        chk("reset_in_ready", 32'(in_ready), 1);

        vecs.push_back(mk("add_wrap",  5'b00000, 32'hFFFFFFFF, 32'h1,        32'h0,        5'b11000));
        vecs.push_back(mk("add_ovf",   5'b00000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 5'b00110));
        vecs.push_back(mk("sub_neg",   5'b00101, 32'h3,        32'h5,        32'hFFFFFFFE, 5'b00010));
        vecs.push_back(mk("beq_eq",    5'b00010, 32'h5,        32'h5,        32'h0,        5'b11001));
        vecs.push_back(mk("bne_eq",    5'b00111, 32'h5,        32'h5,        32'h0,        5'b11000));
        vecs.push_back(mk("jump",      5'b01010, 32'h12345678, 32'h9,        32'h12345678, 5'b00001));
        vecs.push_back(mk("undef_0e",  5'b01110, 32'hFFFF,     32'h1,        32'h0,        5'b10000));
        vecs.push_back(mk("undef_0f",  5'b01111, 32'h5,        32'h5,        32'h0,        5'b10000));
        vecs.push_back(mk("lsl_zero",  5'b01000, 32'hDEADBEEF, 32'h20,       32'hDEADBEEF, 5'b00010));
        vecs.push_back(mk("mrg_ba",    5'b01011, 32'h11112222, 32'h33334444, 32'h33332222, 5'b00000));
        vecs.push_back(mk("mrg_ab",    5'b01100, 32'h11112222, 32'h33334444, 32'h11114444, 5'b00000));
        vecs.push_back(mk("ones",      5'b11111, 32'h0,        32'h0,        32'hFFFFFFFF, 5'b00010));
        vecs.push_back(mk("deca_zero", 5'b00110, 32'h0,        32'h0,        32'hFFFFFFFF, 5'b00010));
        vecs.push_back(mk("subdec",    5'b00100, 32'h5,        32'h2,        32'h2,        5'b01000));
        vecs.push_back(mk("nor",       5'b11000, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 5'b00000));
        vecs.push_back(mk("inca_ovf",  5'b00011, 32'h7FFFFFFF, 32'h0,        32'h80000000, 5'b00110));
        vecs.push_back(mk("sub_ovf",   5'b00101, 32'h80000000, 32'h1,        32'h7FFFFFFF, 5'b01100));
        vecs.push_back(mk("xnor",      5'b11001, 32'h00FF00FF, 32'h0F0F0F0F, 32'hF00FF00F, 5'b00010));

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1; opcode = vecs[i].op; a = vecs[i].va; b = vecs[i].vb;
            #1;
            chk({vecs[i].nm, "_in_ready"}, 32'(in_ready), 1);
            tick();
            in_valid = 1'b0;
            #1;
            chk({vecs[i].nm, "_out_valid"}, 32'(out_valid), 1);
            chk({vecs[i].nm, "_result"}, result, vecs[i].r);
            chk({vecs[i].nm, "_flags"}, flags(), {27'b0, vecs[i].f});
        end
        tick();

        // asr by 4: five-cycle latency, requests blocked while shifting
        in_valid = 1'b1; opcode = 5'b01001; a = 32'h80000010; b = 32'd4;
        #1;
        chk("asr_accept_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("asr_busy_in_ready_c%0d", k), 32'(in_ready), 0);
            chk($sformatf("asr_busy_out_valid_c%0d", k), 32'(out_valid), 0);
            tick();
        end
        chk("asr_out_valid_c5", 32'(out_valid), 1);
        chk("asr_result", result, 32'hF8000001);
        chk("asr_flags", flags(), 32'b00010);
        tick();

        // lsr by 1 completing with the consumer stalled: result held
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 5'b01101; a = 32'h3; b = 32'd1;
        #1;
        chk("lsr_accept_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("lsr_busy_out_valid", 32'(out_valid), 0);
        tick();
        chk("lsr_out_valid", 32'(out_valid), 1);
        chk("lsr_result", result, 32'h1);
        chk("lsr_flags", flags(), 32'b01000);
        tick();
        chk("lsr_hold_out_valid", 32'(out_valid), 1);
        chk("lsr_hold_result", result, 32'h1);
        chk("lsr_hold_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        chk("lsr_drained", 32'(out_valid), 0);

        // backpressure: second add waits, accepted on the drain cycle
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 5'b00000; a = 32'd1; b = 32'd2;
        #1;
        chk("bp_first_in_ready", 32'(in_ready), 1);
        tick();
        a = 32'd10; b = 32'd20;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 1);
            chk($sformatf("bp_hold_result_%0d", k), result, 32'd3);
            chk($sformatf("bp_hold_in_ready_%0d", k), 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_drain_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_second_valid", 32'(out_valid), 1);
        chk("bp_second_result", result, 32'd30);
        tick();
        chk("bp_valid_drop", 32'(out_valid), 0);

        // reset five cycles into a long shift aborts it
        in_valid = 1'b1; opcode = 5'b01000; a = 32'h1; b = 32'd20;
        #1;
        chk("rst_shift_accept", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("rst_mid_shift_in_ready", 32'(in_ready), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_abort_out_valid", 32'(out_valid), 0);
        chk("rst_abort_in_ready", 32'(in_ready), 1);
        chk("rst_abort_result", result, 0);
        chk("rst_abort_flags", flags(), 0);
        saw = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) saw = 1'b1;
            tick();
        end
        chk("rst_abort_no_output", 32'(saw), 0);

        // randomized traffic against the reference model
        cyc = 0; busy_until = 0; m_at = 0; m_has = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            opcode    = 5'($urandom_range(0, 31));
            b         = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = 5'($urandom_range(0, 3));
            a         = $urandom;
            if ($urandom_range(0, 7) == 0) a = b;
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            mvalid  = m_has && (cyc >= m_at);
            exp_inr = (cyc >= busy_until) && (!mvalid || out_ready);
            chk("rnd_out_valid", 32'(out_valid), 32'(mvalid));
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_inr));
            if (mvalid && out_valid) begin
                chk("rnd_result", result, m_res.r);
                chk("rnd_flags", flags(), {27'b0, m_res.f});
            end
            if (mvalid && out_ready) m_has = 1'b0;
            if (in_valid && exp_inr) begin
                m_res      = ref_op(opcode, a, b);
                m_has      = 1'b1;
                m_at       = cyc + latency(opcode, b);
                busy_until = m_at;
            end
            cyc++;
            tick();
        end

        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) tick();
        for (int k = 0; k < 40 && !in_ready; k++) tick();
        tick();
        chk("final_drained", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
